ddc_stream_arbiter: RTL

- Merges the 48-bit I/Q output streams of NCHAN DDC_Block instances into one AXI-Stream, tagging each beat with its channel number.
- Feeds the single RX sample FIFO/DMA path.
- Round-robin fairness; optional pair-synchronised mode emits channels 2k and 2k+1 back-to-back as one atomic pair (for diversity/PureSignal).
- Disabled channels are drained and discarded so upstream DDCs never stall.

---
 rtl/ddc_stream_arbiter_pkg.sv | 20 ++
 rtl/ddc_stream_arbiter_if.sv | 31 +++
 rtl/ddc_stream_arbiter_picker.sv | 36 +++
 rtl/ddc_stream_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ddc_stream_arbiter_pkg.sv
// ddc_stream_arbiter shared types and helpers.
// Feature macro: DDC_ARB_STATS_EN (per-channel beat counters).
package ddc_arb_pkg;

  localparam int IQ_W = 24;
  localparam int DW   = 2 * IQ_W;

  typedef enum logic {
    ARB,
    PAIR2
  } arb_state_t;

  function automatic logic [DW-1:0] pack_iq(
    input logic [IQ_W-1:0] q,
    input logic [IQ_W-1:0] i
  );
    return {q, i};
  endfunction

endpackage

// File: rtl/ddc_stream_arbiter_if.sv
// Stream bundle between DDC sources, the arbiter and the RX sink.
// master = arbiter view, slave = source/sink view.
interface ddc_stream_arbiter_if #(
  parameter int NCHAN = 4,
  parameter int DW    = 48,
  parameter int IDW   = $clog2(NCHAN)
);
  import ddc_arb_pkg::*;

  logic [NCHAN*DW-1:0] s_tdata;
  logic [NCHAN-1:0]    s_tvalid;
  logic [NCHAN-1:0]    s_tready;
  logic [DW-1:0]       m_tdata;
  logic [IDW-1:0]      m_tdest;
  logic                m_tlast;
  logic                m_tvalid;
  logic                m_tready;

  modport master (
    input  s_tdata, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tdest,
    output m_tlast, m_tvalid
  );

  modport slave (
    output s_tdata, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tdest,
    input  m_tlast, m_tvalid
  );

endinterface

// File: rtl/ddc_stream_arbiter_picker.sv
// Round-robin priority picker: first request at or after ptr_i,
// wrapping to the lowest index. Purely combinational.
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_any_o
);
  import ddc_arb_pkg::*;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!gnt_any_o && req_i[j] && j >= int'(ptr_i)) begin
        gnt_oh_o[j] = 1'b1;
        gnt_idx_o   = IW'(j);
        gnt_any_o   = 1'b1;
      end
    end
    // wrap pass: nothing at/after ptr, take lowest
    for (int j = 0; j < N; j++) begin
      if (!gnt_any_o && req_i[j]) begin
        gnt_oh_o[j] = 1'b1;
        gnt_idx_o   = IW'(j);
        gnt_any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddc_stream_arbiter.sv
// Merges NCHAN DDC I/Q streams into one tagged stream, round-robin,
// with optional atomic pairs. Macro DDC_ARB_STATS_EN adds beat_count.
module ddc_stream_arbiter #(
  parameter int NCHAN = 4,
  parameter int DW    = 48,
  parameter int IDW   = $clog2(NCHAN)
) (
  input  logic                 aclk,
  input  logic                 rstn,
  ddc_stream_arbiter_if.master bus,
  input  logic [NCHAN-1:0]     chan_enable,
  input  logic [NCHAN/2-1:0]   pair_sync
`ifdef DDC_ARB_STATS_EN
  ,
  output logic [NCHAN*16-1:0]  beat_count
`endif
);
  import ddc_arb_pkg::*;

  typedef logic [IDW-1:0] idx_t;

  arb_state_t          state_q, state_d;
  idx_t                ptr_q, ptr_d;
  idx_t                pidx_q, pidx_d;
  logic                m_tvalid_q, m_tvalid_d;
  logic [DW-1:0]       m_tdata_q, m_tdata_d;
  idx_t                m_tdest_q, m_tdest_d;
  logic                m_tlast_q, m_tlast_d;

  logic [NCHAN/2-1:0]  pair_act;
  logic [NCHAN-1:0]    req;
  logic [NCHAN-1:0]    gnt_oh;
  idx_t                gnt_idx;
  logic                gnt_any;
  logic [NCHAN-1:0]    sel_oh;
  logic                load;
  logic                fire;
  logic                pair_gnt;
  logic                last;
  idx_t                acc_idx;
  idx_t                nxt_idx;
  logic [DW-1:0]       acc_data;

  // Paired odd members are only reachable through their even partner.
  always_comb begin
    pair_act = '0;
    for (int k = 0; k < NCHAN/2; k++)
      pair_act[k] = pair_sync[k] & chan_enable[2*k]
                  & chan_enable[2*k+1];
    for (int n = 0; n < NCHAN; n++) begin
      req[n] = chan_enable[n] & bus.s_tvalid[n];
      if (pair_act[n/2])
        req[n] = (n % 2 == 0) && bus.s_tvalid[n]
              && bus.s_tvalid[n|1];
    end
  end

  rr_priority_picker #(
    .N  (NCHAN),
    .IW (IDW)
  ) u_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  always_comb begin
    load     = rstn && (!m_tvalid_q || bus.m_tready);
    pair_gnt = 1'b0;
    for (int k = 0; k < NCHAN/2; k++)
      if (gnt_oh[2*k] && pair_act[k]) pair_gnt = 1'b1;

    sel_oh = gnt_oh;
    if (state_q == PAIR2) begin
      for (int n = 0; n < NCHAN; n++)
        sel_oh[n] = (idx_t'(n) == pidx_q);
    end

    fire = (state_q == PAIR2) ? load && |(sel_oh & bus.s_tvalid)
                              : load && gnt_any;
    last    = (state_q == PAIR2) || !pair_gnt;
    acc_idx = (state_q == PAIR2) ? pidx_q : gnt_idx;
    nxt_idx = (acc_idx == idx_t'(NCHAN-1)) ? '0 : acc_idx + 1'b1;

    acc_data = '0;
    for (int n = 0; n < NCHAN; n++) begin
      if (sel_oh[n]) acc_data = bus.s_tdata[n*DW +: DW];
      // disabled channels are always drained
      bus.s_tready[n] = sel_oh[n] ? load : ~chan_enable[n];
    end

    state_d    = state_q;
    ptr_d      = ptr_q;
    pidx_d     = pidx_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tdest_d  = m_tdest_q;
    m_tlast_d  = m_tlast_q;

    if (load) begin
      m_tvalid_d = fire;
      if (fire) begin
        m_tdata_d = acc_data;
        m_tdest_d = acc_idx;
        m_tlast_d = last;
      end
    end

    if (fire) begin
      if (last) begin
        state_d = ARB;
        ptr_d   = nxt_idx;
      end else begin
        state_d = PAIR2;
        pidx_d  = nxt_idx;
      end
    end
  end

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ARB;
      ptr_q      <= '0;
      pidx_q     <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tdest_q  <= '0;
      m_tlast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      pidx_q     <= pidx_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tdest_q  <= m_tdest_d;
      m_tlast_q  <= m_tlast_d;
    end
  end

  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tdest  = m_tdest_q;
  assign bus.m_tlast  = m_tlast_q;

`ifdef DDC_ARB_STATS_EN
  logic [NCHAN*16-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int n = 0; n < NCHAN; n++)
      if (fire && sel_oh[n])
        cnt_d[n*16 +: 16] = cnt_q[n*16 +: 16] + 16'd1;
  end

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign beat_count = cnt_q;
`endif

endmodule
